pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//   Controller on the other side of the system PLL's reset/locked interface. Runs on the free-running
//   50 MHz reference clock. Pulses the PLL's rst input, watches its asynchronous locked output, and
//   holds core_reset until lock has been stable. Retries the PLL reset on lock timeout or prolonged lock
//   loss, and keeps saturating lock statistics for the OSD/status bus.
// PARAMETERS
//   RST_CYCLES     16       refclk cycles that pll_rst is held high per reset pulse (>=1)
//   LOCK_TIMEOUT   500000   max cycles in WAIT_LOCK before the PLL is reset again (10 ms @ 50 MHz)
//   SETTLE_CYCLES  1024     consecutive locked cycles required before core_reset is released
//   RELOCK_CYCLES  5000     max cycles in HOLD waiting for lock to return before the PLL is reset again
// PORTS
//   refclk         in   1   reference clock (50 MHz, free-running, not PLL-derived)
//   rst            in   1   asynchronous, active-high reset
//   pll_locked     in   1   PLL locked output; asynchronous to refclk
//   clear_stats    in   1   synchronous pulse; clears lock_loss_cnt, retry_cnt, timeout_err
//   pll_rst        out  1   drives the PLL rst input
//   core_reset     out  1   reset request to the core; high whenever the sequencer is not in RUN
//   running        out  1   high in RUN only
//   lock_loss_cnt  out  8   RUN->HOLD transitions, saturates at 255
//   retry_cnt      out  4   PLL re-resets caused by a timeout (WAIT_LOCK or HOLD), saturates at 15
//   timeout_err    out  1   sticky; set on any timeout, cleared by clear_stats
// BEHAVIOUR
//   - All outputs are registered. Reset values: pll_rst=1, core_reset=1, running=0, counters=0,
//     timeout_err=0, state=PRST, timer=0.
//   - pll_locked passes through a 2-FF synchronizer (locked_s), giving 2 cycles of latency. The FSM uses
//     only locked_s.
//   - A single timer is shared by all states. It is cleared on every state change. Otherwise it
//     increments each cycle and never wraps: its width is clog2(max(parameters)+1).
//   - States, output columns, and transitions. Outputs in each state are pll_rst / core_reset / running:
//       PRST   1/1/0  timer==RST_CYCLES-1 -> WAIT_LOCK (pll_rst high exactly RST_CYCLES cycles)
//       WAIT_LOCK  0/1/0  locked_s -> SETTLE
//                         timer==LOCK_TIMEOUT-1 -> PRST, retry++, timeout_err=1
//       SETTLE 0/1/0  !locked_s -> WAIT_LOCK (timer restarts)
//                     timer==SETTLE_CYCLES-1 with locked_s -> RUN
//       RUN    0/0/1  !locked_s -> HOLD, lock_loss++
//       HOLD   0/1/0  locked_s -> SETTLE
//                     timer==RELOCK_CYCLES-1 -> PRST, retry++, timeout_err=1
//   - Output registers take the value of the next state. core_reset therefore rises on the same edge
//     that enters HOLD, which is 3 edges after pll_locked falls.
//   - Simultaneous events:
//       - In SETTLE on the terminal cycle, !locked_s wins and the FSM goes to WAIT_LOCK.
//       - In HOLD, locked_s returning on the RELOCK terminal cycle wins and the FSM goes to SETTLE.
//       - clear_stats together with an increment leaves the counter at 1 and timeout_err set if the
//         increment was caused by a timeout.
//   - Counters saturate and never wrap.
//   - rst asserted mid-operation returns everything to reset values asynchronously. The synchronizer
//     flops also reset to 0.
// STRUCTURE
//   - Package pll_seq_pkg:
//       - state enum {PRST, WAIT_LOCK, SETTLE, RUN, HOLD}, 3-bit encoding
//       - LOSS_CNT_W=8, RETRY_CNT_W=4
//       - constant function for the timer width
//   - Sub-module sync_2ff: generic 1-bit async-reset 2-flop synchronizer, reset value parameter.
//   - Top: FSM, timer, stats registers.
// TESTING  (sim parameters RST=4, TIMEOUT=50, SETTLE=8, RELOCK=20)
//   1. Release rst with locked tied 1.
//      -> pll_rst high exactly 4 cycles.
//      -> running=1 and core_reset=0 on cycle 4+1+8 (+/-sync latency, checked exactly against model).
//   2. locked stays 0.
//      -> pll_rst re-pulses every 54 cycles.
//      -> retry_cnt counts 1..15 and holds at 15.
//      -> timeout_err=1.
//      -> clear_stats -> counters and timeout_err become 0.
//   3. In RUN, drop locked for 5 cycles.
//      -> core_reset high 3 edges after the fall.
//      -> lock_loss_cnt=1, FSM passes through SETTLE, back in RUN after 8 locked cycles.
//      -> pll_rst never asserted.
//   4. In RUN, drop locked for 30 cycles.
//      -> HOLD timeout: pll_rst pulse of 4 cycles.
//      -> retry_cnt +1, lock_loss_cnt +1.
//   5. Toggle locked every 5 cycles during SETTLE.
//      -> never reaches RUN.
//      -> WAIT_LOCK timer restarts each time.
//   6. Assert rst mid-SETTLE, and separately force lock_loss_cnt to 255 and lose lock again.
//      -> rst: immediate reset values.
//      -> lock loss at 255: count stays 255.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and sizing for the PLL lock sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PRST      = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } seq_state_t;

  localparam int LOSS_CNT_W  = 8;
  localparam int RETRY_CNT_W = 4;

  // Timer must hold the largest terminal count without wrapping
  function automatic int timer_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with async reset and selectable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // first flop may go metastable; second flop gives it a full cycle to resolve
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses PLL reset, qualifies lock, gates core reset, keeps lock stats
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int RELOCK_CYCLES = 5000
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   clear_stats,
  output logic                   pll_rst,
  output logic                   core_reset,
  output logic                   running,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt,
  output logic [RETRY_CNT_W-1:0] retry_cnt,
  output logic                   timeout_err
);

  localparam int TW = timer_w(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES, RELOCK_CYCLES);
  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] RELOCK_LAST = TW'(RELOCK_CYCLES - 1);

  seq_state_t    state, state_nxt;
  logic [TW-1:0] timer;
  logic          locked_s;
  logic          timeout_ev, loss_ev;
  logic          pll_rst_nxt, core_reset_nxt, running_nxt;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // next-state decode; lock presence beats a timer expiring in the same cycle
  always_comb begin
    state_nxt  = state;
    timeout_ev = 1'b0;
    loss_ev    = 1'b0;
    case (state)
      PRST:      if (timer == RST_LAST) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s) state_nxt = SETTLE;
        else if (timer == LOCK_LAST) begin
          state_nxt  = PRST;
          timeout_ev = 1'b1;
        end
      end
      SETTLE: begin
        if (!locked_s) state_nxt = WAIT_LOCK;
        else if (timer == SETTLE_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = HOLD;
          loss_ev   = 1'b1;
        end
      end
      HOLD: begin
        if (locked_s) state_nxt = SETTLE;
        else if (timer == RELOCK_LAST) begin
          state_nxt  = PRST;
          timeout_ev = 1'b1;
        end
      end
      default: state_nxt = PRST;
    endcase
    // registered outputs follow the state being entered, so they line up with it
    pll_rst_nxt    = (state_nxt == PRST);
    core_reset_nxt = (state_nxt != RUN);
    running_nxt    = (state_nxt == RUN);
  end

  // state and output registers
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= PRST;
      pll_rst    <= 1'b1;
      core_reset <= 1'b1;
      running    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pll_rst    <= pll_rst_nxt;
      core_reset <= core_reset_nxt;
      running    <= running_nxt;
    end
  end

  // shared timer: restarts on every state change, otherwise counts up and sticks at max
  always_ff @(posedge refclk or posedge rst) begin
    if (rst)                            timer <= '0;
    else if (state_nxt != state)        timer <= '0;
    else if (timer != {TW{1'b1}})       timer <= timer + TW'(1);
  end

  // saturating statistics; an event coinciding with clear_stats still counts once
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_loss_cnt <= '0;
      retry_cnt     <= '0;
      timeout_err   <= 1'b0;
    end else begin
      if (clear_stats)                                lock_loss_cnt <= LOSS_CNT_W'(loss_ev);
      else if (loss_ev && (lock_loss_cnt != '1))      lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);

      if (clear_stats)                                retry_cnt <= RETRY_CNT_W'(timeout_ev);
      else if (timeout_ev && (retry_cnt != '1))       retry_cnt <= retry_cnt + RETRY_CNT_W'(1);

      timeout_err <= timeout_ev | (timeout_err & ~clear_stats);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed stimulus with an output-change scoreboard
module tb_pll_lock_sequencer;

  typedef struct packed {
    logic       pr;
    logic       cr;
    logic       rn;
    logic [7:0] lost;
    logic [3:0] retry;
    logic       terr;
  } obs_t;

  typedef struct {
    int   at_edge;
    obs_t v;
  } ev_t;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       clear_stats = 1'b0;
  logic       pll_rst, core_reset, running, timeout_err;
  logic [7:0] lock_loss_cnt;
  logic [3:0] retry_cnt;

  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   e_lost = 0, e_retry = 0, e_terr = 0;
  obs_t exp_last;
  ev_t  sb[$];

  pll_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(50), .SETTLE_CYCLES(8), .RELOCK_CYCLES(20)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .clear_stats(clear_stats),
    .pll_rst(pll_rst), .core_reset(core_reset), .running(running),
    .lock_loss_cnt(lock_loss_cnt), .retry_cnt(retry_cnt), .timeout_err(timeout_err)
  );

  always #10 refclk = ~refclk;
  always @(posedge refclk) edge_cnt++;

  function automatic obs_t sample();
    obs_t o;
    o.pr = pll_rst; o.cr = core_reset; o.rn = running;
    o.lost = lock_loss_cnt; o.retry = retry_cnt; o.terr = timeout_err;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pll_rst=%0b core_reset=%0b running=%0b loss=%0d retry=%0d terr=%0b",
                     o.pr, o.cr, o.rn, o.lost, o.retry, o.terr);
  endfunction

  function automatic obs_t mk(input bit pr, input bit cr, input bit rn);
    obs_t o;
    o.pr = pr; o.cr = cr; o.rn = rn;
    o.lost = 8'(e_lost); o.retry = 4'(e_retry); o.terr = e_terr[0];
    return o;
  endfunction

  // expected output change at a given edge, using the current expected stats
  task automatic push(input int at, input bit pr, input bit cr, input bit rn);
    ev_t e;
    e.at_edge = at;
    e.v = mk(pr, cr, rn);
    if (e.v !== exp_last) begin
      sb.push_back(e);
      exp_last = e.v;
    end
  endtask

  // monitor: every output change must match the next scoreboard entry in value and edge
  obs_t mon_prev, mon_cur;
  ev_t  mon_ev;
  bit   primed = 1'b0;
  always @(negedge refclk) begin
    mon_cur = sample();
    if (primed && (mon_cur !== mon_prev)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change edge=%0d got {%s} expected no change", edge_cnt, fmt(mon_cur));
      end else begin
        mon_ev = sb.pop_front();
        if ((mon_ev.at_edge != edge_cnt) || (mon_cur !== mon_ev.v)) begin
          failures++;
          $display("FAIL out_event got edge=%0d {%s} expected edge=%0d {%s}",
                   edge_cnt, fmt(mon_cur), mon_ev.at_edge, fmt(mon_ev.v));
        end
      end
    end
    mon_prev = mon_cur;
    primed   = 1'b1;
  end

  task automatic wait_edge(input int t);
    while (edge_cnt < t) @(negedge refclk);
  endtask

  // async reset between edges; release on a negedge, n0 = last edge before release
  task automatic do_reset(input bit lk, output int n0);
    obs_t r;
    @(negedge refclk);
    #2;
    pll_locked = lk;
    rst = 1'b1;
    #1;
    r = sample();
    checks++;
    if (r !== 16'h8000 && r !== obs_t'({1'b1, 1'b1, 1'b0, 8'd0, 4'd0, 1'b0})) begin
      failures++;
      $display("FAIL reset_state got {%s} expected pll_rst=1 core_reset=1 running=0 all stats 0", fmt(r));
    end else if (r !== obs_t'({1'b1, 1'b1, 1'b0, 8'd0, 4'd0, 1'b0})) begin
      failures++;
      $display("FAIL reset_state got {%s} expected pll_rst=1 core_reset=1 running=0 all stats 0", fmt(r));
    end
    e_lost = 0; e_retry = 0; e_terr = 0;
    push(edge_cnt + 1, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge refclk);
    rst = 1'b0;
    n0 = edge_cnt;
  endtask

  // short lock loss from RUN (len <= 20 returns before the HOLD timeout)
  task automatic drop(input int len);
    int n;
    n = edge_cnt;
    e_lost = (e_lost < 255) ? e_lost + 1 : 255;
    push(n + 3, 1'b0, 1'b1, 1'b0);
    push(n + len + 11, 1'b0, 0, 1'b1);
    pll_locked = 1'b0;
    repeat (len) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (12) @(negedge refclk);
  endtask

  // 30-cycle lock loss from RUN: HOLD times out and the PLL is reset again
  task automatic drop_long();
    int n;
    n = edge_cnt;
    e_lost = (e_lost < 255) ? e_lost + 1 : 255;
    push(n + 3, 1'b0, 1'b1, 1'b0);
    e_retry = (e_retry < 15) ? e_retry + 1 : 15;
    e_terr = 1;
    push(n + 23, 1'b1, 1'b1, 1'b0);
    push(n + 27, 1'b0, 1'b1, 1'b0);
    push(n + 41, 1'b0, 1'b0, 1'b1);
    pll_locked = 1'b0;
    repeat (30) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (12) @(negedge refclk);
  endtask

  initial begin
    repeat (20000) @(posedge refclk);
    failures++;
    $display("FAIL watchdog expired at edge=%0d, required completion before 20000 edges", edge_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n0, n, s;
    exp_last = obs_t'({1'b1, 1'b1, 1'b0, 8'd0, 4'd0, 1'b0});

    // never locks: PLL re-reset every 4+50 edges, retry saturates at 15
    do_reset(1'b0, n0);
    push(n0 + 4, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      e_retry = (k < 15) ? k : 15;
      e_terr  = 1;
      push(n0 + 54 * k, 1'b1, 1'b1, 1'b0);
      push(n0 + 54 * k + 4, 1'b0, 1'b1, 1'b0);
    end
    // clear_stats on the same edge as the 18th timeout: retry restarts at 1, terr stays
    e_retry = 1; e_terr = 1;
    push(n0 + 972, 1'b1, 1'b1, 1'b0);
    push(n0 + 976, 1'b0, 1'b1, 1'b0);
    wait_edge(n0 + 971);
    clear_stats = 1'b1;
    @(negedge refclk);
    clear_stats = 1'b0;
    // plain clear in WAIT_LOCK
    wait_edge(n0 + 985);
    e_retry = 0; e_terr = 0;
    push(n0 + 986, 1'b0, 1'b1, 1'b0);
    clear_stats = 1'b1;
    @(negedge refclk);
    clear_stats = 1'b0;

    // locked from the start: 4 edges of pll_rst, RUN after 4+1+8
    do_reset(1'b1, n0);
    push(n0 + 4, 1'b0, 1'b1, 1'b0);
    push(n0 + 13, 1'b0, 1'b0, 1'b1);
    wait_edge(n0 + 16);
    drop(5);
    drop_long();
    // drive the loss counter into saturation, last loss at the HOLD relock boundary
    for (int k = 0; k < 253; k++) drop(1);
    drop(20);

    // async reset while in SETTLE with non-zero stats
    n = edge_cnt;
    push(n + 3, 1'b0, 1'b1, 1'b0);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    wait_edge(n + 6);
    do_reset(1'b0, n0);

    // lock chatters during SETTLE: never reaches RUN, no timeout since timer restarts
    push(n0 + 4, 1'b0, 1'b1, 1'b0);
    wait_edge(n0 + 6);
    s = edge_cnt;
    for (int p = 0; p < 12; p++) begin
      pll_locked = 1'b1;
      repeat (5) @(negedge refclk);
      pll_locked = 1'b0;
      repeat (5) @(negedge refclk);
    end
    pll_locked = 1'b1;
    // SETTLE entered at s+123; loss seen on its terminal cycle (s+131) must win over RUN
    wait_edge(s + 128);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    push(s + 140, 1'b0, 1'b0, 1'b1);
    wait_edge(s + 145);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_events got %0d outstanding, first due at edge %0d, expected 0",
               sb.size(), sb[0].at_edge);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
